nnrv_uart_tx: RTL and testbench



---
 rtl/nnrv_uart_tx_if.sv | 23 ++
 rtl/nnrv_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_nnrv_uart_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nnrv_uart_tx_if.sv
// rtl/nnrv_uart_tx_if.sv - mem-stage store/load port bundle for the UART transmitter
interface nnrv_uart_tx_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] i_wr_addr;
    logic            i_wr_en;
    logic [3:0]      i_wr_mask;
    logic [XLEN-1:0] i_wr_data;
    logic [XLEN-1:0] i_rd_addr;
    logic            i_rd_en;
    logic [XLEN-1:0] o_rd_data;
    logic            o_rd_hit;

    modport master (
        output i_wr_addr, i_wr_en, i_wr_mask, i_wr_data, i_rd_addr, i_rd_en,
        input  o_rd_data, o_rd_hit
    );

    modport slave (
        input  i_wr_addr, i_wr_en, i_wr_mask, i_wr_data, i_rd_addr, i_rd_en,
        output o_rd_data, o_rd_hit
    );
endinterface

// File: rtl/nnrv_uart_tx.sv
// rtl/nnrv_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status register
module nnrv_uart_tx #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] BASE_ADDR    = 'h400,
    parameter int unsigned     FIFO_DEPTH   = 4,
    parameter int unsigned     CLKS_PER_BIT = 434
) (
    input  logic          i_clk,
    input  logic          i_rst,
    nnrv_uart_tx_if.slave bus,
    output logic          o_tx,
    output logic          o_busy
);
    localparam int unsigned     AW          = $clog2(FIFO_DEPTH);
    localparam int unsigned     CW          = AW + 1;
    localparam int unsigned     BW          = $clog2(CLKS_PER_BIT);
    localparam logic [XLEN-1:0] STATUS_ADDR = BASE_ADDR + XLEN'(4);
    localparam logic [BW-1:0]   BIT_LAST    = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   DEPTH_C     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            ovf_q;

    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            rd_hit_q, rd_hit_d;
    logic [XLEN-1:0] status;

    logic full, empty, push_req, push, pop, ovf_clr;
    logic unused_wr_bits;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign push_req = bus.i_wr_en && (bus.i_wr_addr == BASE_ADDR) && bus.i_wr_mask[0];
    assign push     = push_req && !full;
    assign ovf_clr  = bus.i_wr_en && (bus.i_wr_addr == STATUS_ADDR) && bus.i_wr_mask[0]
                      && bus.i_wr_data[3];
    assign unused_wr_bits = ^{bus.i_wr_mask[3:1], bus.i_wr_data[XLEN-1:8]};

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.i_wr_data[7:0];
        end
    end

    // Full is taken from the registered count, so a push while full is lost even if a pop frees a slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req && full) ovf_q <= 1'b1;
            else if (ovf_clr)     ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // tx_d is the line level for the state being entered, keeping o_tx a plain register.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem[rd_ptr_q];
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign status = XLEN'({4'(count_q), ovf_q, state_q != S_IDLE, empty, full});

    always_comb begin
        rd_hit_d  = 1'b0;
        rd_data_d = rd_data_q;
        if (bus.i_rd_en) begin
            rd_data_d = '0;
            if (bus.i_rd_addr == BASE_ADDR) begin
                rd_hit_d = 1'b1;
            end else if (bus.i_rd_addr == STATUS_ADDR) begin
                rd_hit_d  = 1'b1;
                rd_data_d = status;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    assign bus.o_rd_data = rd_data_q;
    assign bus.o_rd_hit  = rd_hit_q;
    assign o_tx          = tx_q;
    assign o_busy        = (state_q != S_IDLE) || !empty;
endmodule

// File: tb/tb_nnrv_uart_tx.sv
// tb/tb_nnrv_uart_tx.sv - scoreboard bench for nnrv_uart_tx with a queue/frame-timer reference model
module tb_nnrv_uart_tx;
    localparam int          C     = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam logic [31:0] STAT  = 32'h0000_0404;

    typedef struct { logic [7:0] b; int at; } tx_exp_t;
    typedef struct { logic hit; logic [31:0] data; } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o_tx, o_busy;

    nnrv_uart_tx_if #(.XLEN(32)) bus();

    nnrv_uart_tx #(
        .XLEN(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(C)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus), .o_tx(o_tx), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: FIFO contents as a byte queue, transmitter as cycles left in the current frame.
    logic [7:0] mq[$];
    int         m_left = 0;
    logic       m_ovf  = 1'b0;
    tx_exp_t    exp_tx[$];
    rd_exp_t    rd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] status_word(input int n, input logic busy, input logic ovf);
        return ((n % 16) * 16) + (ovf ? 8 : 0) + (busy ? 4 : 0) + ((n == 0) ? 2 : 0) + ((n == DEPTH) ? 1 : 0);
    endfunction

    task automatic step(input logic we, input logic [31:0] wa, input logic [3:0] wm,
                        input logic [31:0] wd, input logic re, input logic [31:0] ra);
        int      pre_n;
        rd_exp_t r;
        tx_exp_t t;
        bus.i_wr_en = we; bus.i_wr_addr = wa; bus.i_wr_mask = wm; bus.i_wr_data = wd;
        bus.i_rd_en = re; bus.i_rd_addr = ra;
        pre_n = mq.size();
        if (re) begin
            r.hit  = (ra == BASE) || (ra == STAT);
            r.data = (ra == STAT) ? status_word(pre_n, m_left > 0, m_ovf) : 32'h0;
            rd_q.push_back(r);
        end
        if (m_left <= 1 && pre_n > 0) begin
            t.b = mq.pop_front();
            t.at = cyc + 1;
            exp_tx.push_back(t);
            m_left = 10 * C;
        end else if (m_left > 0) begin
            m_left--;
        end
        if (we && wa == BASE && wm[0]) begin
            if (pre_n == DEPTH) m_ovf = 1'b1;
            else mq.push_back(wd[7:0]);
        end else if (we && wa == STAT && wm[0] && wd[3]) begin
            m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("busy", {31'b0, o_busy}, {31'b0, (m_left > 0) || (mq.size() > 0)});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic push(input logic [7:0] b);
        step(1'b1, BASE, 4'b0001, {$urandom_range(0, 255), 16'h0, b}, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, a);
    endtask

    task automatic do_reset();
        bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_mask = '0; bus.i_wr_data = '0;
        bus.i_rd_en = 1'b0; bus.i_rd_addr = '0;
        rst = 1'b1;
        #1;
        chk("rst_tx_async", {31'b0, o_tx}, 32'h1);
        chk("rst_busy_async", {31'b0, o_busy}, 32'h0);
        mq.delete(); exp_tx.delete(); rd_q.delete();
        m_left = 0; m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Frame monitor: decodes o_tx and checks each frame against the next expected byte and start cycle.
    logic    mon_active = 1'b0;
    logic    mon_have   = 1'b0;
    int      mon_t      = 0;
    logic [7:0] mon_byte;
    tx_exp_t mon_cur;
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (o_tx !== 1'b1) begin
                mon_active = 1'b1;
                mon_t = 0;
                mon_byte = 8'h0;
                if (exp_tx.size() == 0) begin
                    mon_have = 1'b0;
                    checks++; errors++;
                    $display("FAIL unexpected_frame: got start at cycle %0d expected no frame", cyc);
                end else begin
                    mon_have = 1'b1;
                    mon_cur = exp_tx.pop_front();
                    chk("frame_start_cycle", cyc, mon_cur.at);
                end
            end
        end else begin
            mon_t++;
            if ((mon_t % C) == C / 2) begin
                if (mon_t / C == 0) chk("start_bit", {31'b0, o_tx}, 32'h0);
                else if (mon_t / C <= 8) mon_byte[mon_t / C - 1] = o_tx;
                else begin
                    chk("stop_bit", {31'b0, o_tx}, 32'h1);
                    if (mon_have) chk("frame_byte", {24'b0, mon_byte}, {24'b0, mon_cur.b});
                end
            end
            if (mon_t == C / 2) chk("start_bit", {31'b0, o_tx}, 32'h0);
            if (mon_t == 10 * C - 1) mon_active = 1'b0;
        end
    end

    logic        rd_pend;
    logic [31:0] last_rd = 32'h0;
    rd_exp_t     rd_cur;
    always @(posedge clk or posedge rst) begin
        if (rst) rd_pend <= 1'b0;
        else     rd_pend <= bus.i_rd_en;
    end

    always @(negedge clk) begin
        if (rst) begin
            last_rd = 32'h0;
        end else if (rd_pend) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got a load response expected none");
            end else begin
                rd_cur = rd_q.pop_front();
                chk("rd_hit", {31'b0, bus.o_rd_hit}, {31'b0, rd_cur.hit});
                chk("rd_data", bus.o_rd_data, rd_cur.data);
                last_rd = rd_cur.data;
            end
        end else begin
            chk("rd_hit_idle", {31'b0, bus.o_rd_hit}, 32'h0);
            chk("rd_data_hold", bus.o_rd_data, last_rd);
        end
    end

    initial begin
        int k;
        int op;
        bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_mask = '0; bus.i_wr_data = '0;
        bus.i_rd_en = 1'b0; bus.i_rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx", {31'b0, o_tx}, 32'h1);
        chk("rst_busy", {31'b0, o_busy}, 32'h0);
        chk("rst_rd_data", bus.o_rd_data, 32'h0);
        chk("rst_rd_hit", {31'b0, bus.o_rd_hit}, 32'h0);
        rst = 1'b0;
        idle(2);

        push(8'h55);
        idle(45);
        rd(STAT);

        for (int i = 1; i <= 6; i++) push(8'(i));
        rd(STAT);
        step(1'b1, STAT, 4'b0001, 32'h8, 1'b0, 32'h0);
        rd(STAT);
        idle(230);

        step(1'b1, BASE, 4'b1110, 32'hAB, 1'b0, 32'h0);
        step(1'b1, BASE + 32'd8, 4'b0001, 32'hCD, 1'b0, 32'h0);
        rd(BASE + 32'd8);
        rd(STAT);
        rd(BASE);
        idle(10);

        push(8'hA5);
        idle(18);
        do_reset();
        rd(STAT);
        idle(60);

        push(8'h3C); push(8'hC3); push(8'h81);
        for (k = 0; k < 200 && m_left != 1; k++) idle(1);
        if (m_left != 1) begin
            checks++; errors++;
            $display("FAIL stop_align_timeout: got no last stop cycle expected one within 200 cycles");
        end
        push(8'h7E);
        rd(STAT);
        idle(170);

        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: push(8'($urandom_range(0, 255)));
                4:       rd(STAT);
                5:       rd((($urandom_range(0, 1)) != 0) ? BASE : (BASE + 32'd8));
                6:       step(1'b1, STAT, 4'($urandom_range(0, 15)), $urandom, 1'b0, 32'h0);
                7:       step(1'b1, BASE + 32'($urandom_range(1, 12)), 4'hF, $urandom, 1'b0, 32'h0);
                default: idle(1);
            endcase
        end

        for (k = 0; k < 2000 && (mq.size() > 0 || m_left > 0); k++) idle(1);
        idle(5);
        chk("drain_model_idle", {31'b0, (mq.size() > 0) || (m_left > 0)}, 32'h0);
        chk("exp_tx_drained", exp_tx.size(), 32'h0);
        chk("rd_q_drained", rd_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
